// File: rtl/mp_add_seq.sv
// Multi-precision adder: one N-bit ripple-carry slice reused over K words, one word per cycle.
// Define MP_ADD_SEQ_SUB_EN to add a 'sub' port that turns the operation into a - b.
module mp_add_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N*K-1:0] a_in,
  input  logic [N*K-1:0] b_in,
  input  logic         cin,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N*K-1:0] sum_out,
  output logic         cout
);

  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic          cout_q, cout_d;

  logic [N-1:0]  slice_a, slice_b, slice_s;
  logic [N:0]    rc;
  logic          b_inv, cin_eff;

`ifdef MP_ADD_SEQ_SUB_EN
  // Subtraction as a + ~b + 1: invert B at capture, force the initial carry.
  assign b_inv   = sub;
  assign cin_eff = sub | cin & ~sub;
`else
  assign b_inv   = 1'b0;
  assign cin_eff = cin;
`endif

  // Word slice selected by the running index; explicit ripple chain.
  always_comb begin
    slice_a = a_q[int'(idx_q)*N +: N];
    slice_b = b_q[int'(idx_q)*N +: N];
    slice_s = '0;
    rc      = '0;
    rc[0]   = carry_q;
    for (int j = 0; j < N; j++) begin
      slice_s[j] = slice_a[j] ^ slice_b[j] ^ rc[j];
      rc[j+1]    = (slice_a[j] & slice_b[j]) | (rc[j] & (slice_a[j] ^ slice_b[j]));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      RUN: begin
        acc_d[int'(idx_q)*N +: N] = slice_s;
        carry_d = rc[N];
        if (idx_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = rc[N];
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          a_d     = a_in;
          b_d     = b_inv ? ~b_in : b_in;
          carry_d = cin_eff;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: N=4/K=4 instance plus an N=8/K=1 instance.
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cin;
  logic [15:0] a_in, b_in, sum_out;
  logic        busy, done, cout;
  logic        start1, cin1;
  logic [7:0]  a1, b1, sum1;
  logic        busy1, done1, cout1;
`ifdef MP_ADD_SEQ_SUB_EN
  logic        sub;
`endif

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];
  logic [8:0]  exp1_q[$];

  always #5 clk = ~clk;

  mp_add_seq #(.N(4), .K(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef MP_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  mp_add_seq #(.N(8), .K(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
`ifdef MP_ADD_SEQ_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  function automatic logic [16:0] add_model(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  // Waits for done on u0, at most maxc cycles; n returns cycles elapsed.
  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < maxc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, cout, sum_out} !== 19'd0) begin
      bad++; $display("FAIL reset_u0: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum_out);
    end
    total++;
    if ({busy1, done1, cout1, sum1} !== 11'd0) begin
      bad++; $display("FAIL reset_u1: got busy=%b done=%b cout=%b sum=%h want all 0", busy1, done1, cout1, sum1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_chain();
    int n, nb;
    logic [16:0] e, held;
    a_in = 16'hFFFF; b_in = 16'h0001; cin = 1'b0; start = 1'b1;
    exp_q.push_back(add_model(16'hFFFF, 16'h0001, 1'b0));
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
    end while (!done && n < 20);
    total++;
    if (done !== 1'b1 || n != 5) begin
      bad++; $display("FAIL chain_latency: got done=%b after %0d cycles want done=1 after 5", done, n);
    end
    total++;
    if (nb != 4 || busy !== 1'b0) begin
      bad++; $display("FAIL chain_busy: got %0d busy cycles busy_at_done=%b want 4 and 0", nb, busy);
    end
    e = exp_q.pop_front();
    total++;
    if ({cout, sum_out} !== e) begin
      bad++; $display("FAIL chain_result: got %h want %h", {cout, sum_out}, e);
    end
    held = {cout, sum_out};
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || {cout, sum_out} !== held) begin
      bad++; $display("FAIL chain_hold: got done=%b busy=%b res=%h want 0 0 %h", done, busy, {cout, sum_out}, held);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    logic [16:0] e, prev;
    logic changed;
    prev = {cout, sum_out};
    changed = 1'b0;
    a_in = 16'h1234; b_in = 16'h4321; cin = 1'b1; start = 1'b1;
    exp_q.push_back(add_model(16'h1234, 16'h4321, 1'b1));
    @(negedge clk);
    start = 1'b0;
    if ({cout, sum_out} !== prev) changed = 1'b1;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin = 1'b1; start = 1'b1;
    if ({cout, sum_out} !== prev) changed = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 16'h0000; b_in = 16'h0000; cin = 1'b0;
    if ({cout, sum_out} !== prev) changed = 1'b1;
    total++;
    if (changed) begin
      bad++; $display("FAIL run_hold: sum_out moved during RUN got %h want %h", {cout, sum_out}, prev);
    end
    wait_done(20, n);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL ignore_done: got done=%b want 1", done);
    end
    e = exp_q.pop_front();
    total++;
    if ({cout, sum_out} !== e) begin
      bad++; $display("FAIL ignore_result: got %h want %h", {cout, sum_out}, e);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL ignore_no_rerun: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [16:0] e;
    a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0; start = 1'b1;
    exp_q.push_back(add_model(16'h1111, 16'h2222, 1'b0));
    @(negedge clk);
    a_in = 16'h00FF; b_in = 16'h0F01; cin = 1'b0;
    exp_q.push_back(add_model(16'h00FF, 16'h0F01, 1'b0));
    wait_done(20, n);
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || {cout, sum_out} !== e) begin
      bad++; $display("FAIL b2b_first: got done=%b res=%h want 1 %h", done, {cout, sum_out}, e);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_restart: got busy=%b want 1", busy);
    end
    wait_done(20, n);
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || {cout, sum_out} !== e) begin
      bad++; $display("FAIL b2b_second: got done=%b res=%h want 1 %h", done, {cout, sum_out}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    a_in = 16'h0001; b_in = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, cout, sum_out} !== 19'd0) begin
      bad++; $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum_out);
    end
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL midrun_quiet: got busy/done activity=%b want 0", seen);
    end
  endtask

  task automatic test_k1();
    int n, nb;
    logic [8:0] e;
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0; start1 = 1'b1;
    exp1_q.push_back(9'(a1) + 9'(b1) + 9'(cin1));
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0;
      n++;
      if (busy1) nb++;
    end while (!done1 && n < 10);
    total++;
    if (done1 !== 1'b1 || n != 2 || nb != 1) begin
      bad++; $display("FAIL k1_timing: got done=%b at %0d busy=%0d want 1 at 2 busy=1", done1, n, nb);
    end
    e = exp1_q.pop_front();
    total++;
    if ({cout1, sum1} !== e) begin
      bad++; $display("FAIL k1_result: got %h want %h", {cout1, sum1}, e);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int n;
    logic [16:0] e;
    for (int i = 0; i < 6; i++) begin
      a_in = 16'($urandom); b_in = 16'($urandom); cin = 1'($urandom);
      start = 1'b1;
      exp_q.push_back(add_model(a_in, b_in, cin));
      @(negedge clk);
      start = 1'b0;
      wait_done(20, n);
      e = exp_q.pop_front();
      total++;
      if (done !== 1'b1 || {cout, sum_out} !== e) begin
        bad++; $display("FAIL random_%0d: got done=%b res=%h want 1 %h", i, done, {cout, sum_out}, e);
      end
      @(negedge clk);
    end
  endtask

`ifdef MP_ADD_SEQ_SUB_EN
  task automatic test_sub();
    int n;
    logic [16:0] e;
    logic [15:0] av[2], bv[2];
    av[0] = 16'h0005; bv[0] = 16'h0007;
    av[1] = 16'h0007; bv[1] = 16'h0005;
    for (int i = 0; i < 2; i++) begin
      a_in = av[i]; b_in = bv[i]; cin = 1'(i); sub = 1'b1; start = 1'b1;
      exp_q.push_back(17'(av[i]) + 17'(~bv[i]) + 17'd1);
      @(negedge clk);
      start = 1'b0; sub = 1'b0;
      wait_done(20, n);
      e = exp_q.pop_front();
      total++;
      if (done !== 1'b1 || {cout, sum_out} !== e) begin
        bad++; $display("FAIL sub_%0d: got done=%b res=%h want 1 %h", i, done, {cout, sum_out}, e);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_carry_chain();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_k1();
    test_random();
`ifdef MP_ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the adder slice width in bits (N >= 1).
REQ-002 The block SHALL have parameter K, default 4, meaning the number of N-bit words per operand (K >= 1).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request to begin an add; sampled on the clk rising edge.
REQ-006 The block SHALL have port a_in  input  N*K  operand A, captured when start is accepted.
REQ-007 The block SHALL have port b_in  input  N*K  operand B, captured when start is accepted.
REQ-008 The block SHALL have port cin  input  1  carry-in, captured when start is accepted.
REQ-009 The block SHALL have port busy  output  1  high while words are being processed.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum_out  output  N*K  result of the last completed operation.
REQ-012 The block SHALL have port cout  output  1  carry-out of the last completed operation.

Function
REQ-013 The block SHALL compute {cout, sum_out} = a_in + b_in + cin using one N-bit ripple-carry adder slice, reused once per word, with K-word sequencing.
REQ-014 The block SHALL implement the states IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 The block SHALL accept start only when busy = 0 (in IDLE or DONE); when accepted, it SHALL capture a_in, b_in and cin and enter RUN.
REQ-016 The block SHALL ignore start while in RUN; captured operands SHALL NOT change during RUN.
REQ-017 In RUN, the block SHALL process word i (bits i*N+N-1 : i*N), i = 0..K-1 ascending, in the i-th RUN cycle, which is exactly one word per cycle.
REQ-018 The carry into word 0 SHALL be the captured cin; the carry into word i>0 SHALL be the registered carry-out of word i-1.
REQ-019 The block SHALL hold busy = 1 for exactly K consecutive cycles, starting the cycle after start is accepted.
REQ-020 After the last word, the block SHALL enter DONE for exactly one cycle with done = 1 and busy = 0; total latency is start-sample edge to done = K+1 cycles.
REQ-021 The block SHALL update sum_out and cout only on the edge entering DONE, and SHALL hold them stable until the next entry to DONE.
REQ-022 From DONE, the block SHALL go to RUN if start = 1 (back-to-back accept) and otherwise to IDLE.
REQ-023 For K = 1, RUN SHALL last one cycle, and done SHALL follow on the next cycle.
REQ-024 The word index counter SHALL be wide enough for K-1, SHALL restart at 0 on every accepted start, and SHALL NOT wrap during a RUN.

Reset
REQ-025 When rst_n = 0 at a clk edge, the block SHALL set state = IDLE, busy = 0, done = 0, sum_out = 0, cout = 0, and clear the index, carry and operand registers.
REQ-026 If reset occurs mid-RUN, the block SHALL abort the operation without a done pulse; start sampled while rst_n = 0 SHALL be ignored.

Configuration
REQ-027 When the macro MP_ADD_SEQ_SUB_EN is defined, the block SHALL add an input port sub (1 bit, captured with the operands); with sub = 1 the block SHALL compute a_in + ~b_in + 1 and ignore cin, and cout = 1 SHALL mean no borrow.
REQ-028 When MP_ADD_SEQ_SUB_EN is undefined, the block SHALL have no sub port and SHALL perform addition only.

Verification
REQ-029 N=4, K=4: a_in=0xFFFF, b_in=0x0001, cin=0 -> sum_out=0x0000, cout=1, done exactly 5 cycles after the start-sample edge, busy high for 4 cycles.
REQ-030 N=4, K=4: a_in=0x1234, b_in=0x4321, cin=1 -> sum_out=0x5556, cout=0; start re-pulsed during RUN with different operands -> ignored, same result.
REQ-031 Back-to-back: start held high through DONE with new operands 0x00FF + 0x0F01 -> second RUN begins the cycle after done, giving sum_out=0x1000, cout=0.
REQ-032 Reset mid-RUN (rst_n=0 in the 2nd busy cycle) -> next cycle busy=0, done=0, sum_out=0, cout=0; no done pulse afterwards.
REQ-033 N=8, K=1: a_in=0x80, b_in=0x80, cin=0 -> sum_out=0x00, cout=1, done 2 cycles after the start-sample edge.
REQ-034 MP_ADD_SEQ_SUB_EN defined, N=4, K=4, sub=1: 0x0005 - 0x0007 -> sum_out=0xFFFE, cout=0; 0x0007 - 0x0005 -> sum_out=0x0002, cout=1.
